// File: rtl/vga_timing_detector.sv
// VGA timing detector: recovers hcount/vcount from active-low hsync/vsync,
// checks sync phase and width against the configured mode and reports lock.
module vga_timing_detector #(
  parameter int unsigned HD          = 640,
  parameter int unsigned HF          = 16,
  parameter int unsigned HR          = 96,
  parameter int unsigned HB          = 48,
  parameter int unsigned VD          = 480,
  parameter int unsigned VF          = 10,
  parameter int unsigned VR          = 2,
  parameter int unsigned VB          = 33,
  parameter int unsigned H_W         = 10,
  parameter int unsigned V_W         = 10,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           en_i,
  input  logic           vga_hs_i,
  input  logic           vga_vs_i,
  output logic [H_W-1:0] hcount_o,
  output logic [V_W-1:0] vcount_o,
  output logic           pixel_enable_o,
  output logic           locked_o,
  output logic           sync_err_o
);

  localparam int unsigned HTOTAL  = HD + HF + HR + HB;
  localparam int unsigned VTOTAL  = VD + VF + VR + VB;
  localparam int unsigned H_SYNC0 = HD + HF;
  localparam int unsigned H_SYNC1 = HD + HF + HR;
  localparam int unsigned V_SYNC0 = VD + VF;
  localparam int unsigned CNT_W   = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES) : 1;

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_HALIGN = 2'd1,
    S_VERIFY = 2'd2,
    S_LOCKED = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hs_q, vs_q;
  logic [H_W-1:0]   hcount_d, hnext;
  logic [V_W-1:0]   vcount_d, vnext;
  logic             hs_fall, hs_rise, vs_fall;
  logic             h_wrap, tracking, v_check, vexp;
  logic             err_h, err_v, err_c;
  logic             locked_d, pe_d;

  // Next-count, error detection, alignment loads and lock sequencing
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hcount_d = hcount_o;
    vcount_d = vcount_o;
    err_c    = 1'b0;

    hs_fall  = hs_q & ~vga_hs_i;
    hs_rise  = ~hs_q & vga_hs_i;
    vs_fall  = vs_q & ~vga_vs_i;

    h_wrap   = (hcount_o == H_W'(HTOTAL - 1));
    hnext    = h_wrap ? '0 : hcount_o + H_W'(1);
    if (h_wrap) begin
      vnext = (vcount_o == V_W'(VTOTAL - 1)) ? '0 : vcount_o + V_W'(1);
    end else begin
      vnext = vcount_o;
    end

    tracking = (state_q != S_SEARCH);
    v_check  = (state_q == S_VERIFY) || (state_q == S_LOCKED);
    vexp     = (hnext == '0) && (vnext == V_W'(V_SYNC0));

    err_h = tracking & ((hs_fall & (hnext != H_W'(H_SYNC0))) |
                        (~hs_fall & (hnext == H_W'(H_SYNC0))) |
                        (hs_rise & (hnext != H_W'(H_SYNC1))));
    err_v = v_check & (vs_fall ^ vexp);

    if (en_i) begin
      err_c    = err_h | err_v;
      hcount_d = hs_fall ? H_W'(H_SYNC0) : hnext;
      vcount_d = (vs_fall && tracking) ? V_W'(V_SYNC0) : vnext;
      if (err_c) begin
        state_d = S_SEARCH;
        cnt_d   = '0;
      end else begin
        case (state_q)
          S_SEARCH: if (hs_fall) state_d = S_HALIGN;
          S_HALIGN: if (vs_fall) begin
            state_d = S_VERIFY;
            cnt_d   = '0;
          end
          S_VERIFY: if (vs_fall) begin
            if (cnt_q == CNT_W'(LOCK_FRAMES - 1)) state_d = S_LOCKED;
            else                                  cnt_d   = cnt_q + CNT_W'(1);
          end
          S_LOCKED: state_d = S_LOCKED;
          default:  state_d = S_SEARCH;
        endcase
      end
    end

    locked_d = (state_d == S_LOCKED);
    pe_d     = locked_d && (hcount_d < H_W'(HD)) && (vcount_d < V_W'(VD));
  end

  // State, frame counter and sync sample registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_SEARCH;
      cnt_q   <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (en_i) begin
        hs_q <= vga_hs_i;
        vs_q <= vga_vs_i;
      end
    end
  end

  // Registered outputs; error pulse clears on the following clock
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hcount_o       <= '0;
      vcount_o       <= '0;
      pixel_enable_o <= 1'b0;
      locked_o       <= 1'b0;
      sync_err_o     <= 1'b0;
    end else begin
      hcount_o       <= hcount_d;
      vcount_o       <= vcount_d;
      pixel_enable_o <= pe_d;
      locked_o       <= locked_d;
      sync_err_o     <= err_c;
    end
  end

endmodule

// File: tb/tb_vga_timing_detector.sv
// Bench for vga_timing_detector: small video mode, sync generator with fault
// injection, and a frame-level reference model compared every clock.
module tb_vga_timing_detector;

  localparam int HD = 16, HF = 2, HR = 4, HB = 3;
  localparam int VD = 8,  VF = 2, VR = 2, VB = 3;
  localparam int HT = HD + HF + HR + HB;
  localparam int VT = VD + VF + VR + VB;
  localparam int HSS = HD + HF;
  localparam int HSE = HD + HF + HR;
  localparam int VSS = VD + VF;
  localparam int LF = 2;
  localparam int FRAME = HT * VT;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       en_i = 1'b0;
  logic       vga_hs_i = 1'b1;
  logic       vga_vs_i = 1'b1;
  logic [9:0] hcount_o;
  logic [9:0] vcount_o;
  logic       pixel_enable_o, locked_o, sync_err_o;

  vga_timing_detector #(
    .HD(HD), .HF(HF), .HR(HR), .HB(HB), .VD(VD), .VF(VF), .VR(VR), .VB(VB),
    .H_W(10), .V_W(10), .LOCK_FRAMES(LF)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
    .vga_hs_i(vga_hs_i), .vga_vs_i(vga_vs_i),
    .hcount_o(hcount_o), .vcount_o(vcount_o),
    .pixel_enable_o(pixel_enable_o), .locked_o(locked_o), .sync_err_o(sync_err_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // generator state and fault knobs
  int gh = 0, gv = 0, last_gh = 0, last_gv = 0;
  bit arm_stretch = 0, arm_drop = 0, drop_on = 0, arm_vdelay = 0, vdelay_on = 0, arm_glitch = 0;
  int glitch_h = 0;

  // reference model state: tracking horizontally, vsync seen, good frames
  int m_h = 0, m_v = 0, m_frames = 0;
  bit m_hs = 1, m_vs = 1, m_track = 0, m_vseen = 0, m_err = 0, m_pe = 0, m_locked = 0;

  // scenario bookkeeping
  int pulses = 0;
  bit saw_unlock = 0;
  bit chk_gen = 0;
  int cyc = 0;

  task automatic gen_sample(output logic hs, output logic vs);
    bit h_low, v_low;
    int vstart;
    if (gh == 0 && gv == 0) begin
      vdelay_on  = arm_vdelay;
      arm_vdelay = 0;
    end
    h_low = (gh >= HSS) && (gh < HSE);
    if (arm_stretch && gh == HSE) begin
      h_low = 1;
      arm_stretch = 0;
    end
    if (arm_drop && gh == HSS) begin
      drop_on = 1;
      arm_drop = 0;
    end
    if (drop_on) begin
      h_low = 0;
      if (gh == HSE - 1) drop_on = 0;
    end
    if (arm_glitch && gh == glitch_h) begin
      h_low = !h_low;
      arm_glitch = 0;
    end
    vstart = VSS + (vdelay_on ? 1 : 0);
    v_low = (gv >= vstart) && (gv < vstart + VR);
    hs = !h_low;
    vs = !v_low;
    last_gh = gh;
    last_gv = gv;
    gh = (gh + 1) % HT;
    if (gh == 0) gv = (gv + 1) % VT;
  endtask

  task automatic model_clock(input bit rst, input bit en, input bit hs, input bit vs);
    int hn, vn;
    bit hf, hr, vf, fault, vexp;
    if (rst) begin
      m_h = 0; m_v = 0; m_hs = 1; m_vs = 1;
      m_track = 0; m_vseen = 0; m_frames = 0;
      m_err = 0; m_pe = 0; m_locked = 0;
      return;
    end
    m_err = 0;
    if (!en) return;
    hn = (m_h + 1) % HT;
    vn = (hn == 0) ? (m_v + 1) % VT : m_v;
    hf = m_hs && !hs;
    hr = !m_hs && hs;
    vf = m_vs && !vs;
    fault = 0;
    if (m_track) begin
      if (hf && hn != HSS) fault = 1;
      if (!hf && hn == HSS) fault = 1;
      if (hr && hn != HSE) fault = 1;
      if (m_vseen) begin
        vexp = (hn == 0) && (vn == VSS);
        if (vf != vexp) fault = 1;
      end
    end
    m_h = hf ? HSS : hn;
    m_v = (vf && m_track) ? VSS : vn;
    if (fault) begin
      m_track = 0; m_vseen = 0; m_frames = 0; m_err = 1;
    end else if (!m_track) begin
      if (hf) m_track = 1;
    end else if (!m_vseen) begin
      if (vf) begin
        m_vseen = 1;
        m_frames = 0;
      end
    end else if (vf && m_frames < LF) begin
      m_frames++;
    end
    m_hs = hs;
    m_vs = vs;
    m_locked = m_vseen && (m_frames == LF);
    m_pe = m_locked && (m_h < HD) && (m_v < VD);
  endtask

  task automatic step(input bit en, input bit rst);
    logic hs, vs;
    @(negedge clk_i);
    if (en) begin
      gen_sample(hs, vs);
    end else begin
      hs = 1'($urandom);
      vs = 1'($urandom);
    end
    rst_i = rst;
    en_i = en;
    vga_hs_i = hs;
    vga_vs_i = vs;
    model_clock(rst, en, hs, vs);
    cyc++;
    @(posedge clk_i);
    #1;
    check_val("hcount", 32'(hcount_o), 32'(m_h));
    check_val("vcount", 32'(vcount_o), 32'(m_v));
    check_val("locked", 32'(locked_o), 32'(m_locked));
    check_val("sync_err", 32'(sync_err_o), 32'(m_err));
    check_val("pix_en", 32'(pixel_enable_o), 32'(m_pe));
    if (chk_gen && m_locked) begin
      check_val("gen_h", 32'(hcount_o), 32'(last_gh));
      check_val("gen_v", 32'(vcount_o), 32'(last_gv));
    end
    if (sync_err_o === 1'b1) pulses++;
    if (locked_o !== 1'b1) saw_unlock = 1;
  endtask

  function automatic bit pick_en(input int mode);
    case (mode)
      1:       return (cyc % 4) == 0;
      2:       return 1'($urandom_range(0, 1));
      default: return 1'b1;
    endcase
  endfunction

  task automatic run(input int n, input int mode);
    for (int i = 0; i < n; i++) step(pick_en(mode), 1'b0);
  endtask

  task automatic start_phase();
    pulses = 0;
    saw_unlock = 0;
  endtask

  initial begin
    // reset state
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check_val("rst_h", 32'(hcount_o), 0);
    check_val("rst_v", 32'(vcount_o), 0);
    check_val("rst_lock", 32'(locked_o), 0);
    check_val("rst_err", 32'(sync_err_o), 0);

    // clean acquisition at full rate
    start_phase();
    chk_gen = 1;
    run(5 * FRAME, 0);
    chk_gen = 0;
    check_val("p1_lock", 32'(locked_o), 1);
    check_val("p1_pulses", 32'(pulses), 0);

    // stretched hsync pulse
    start_phase();
    arm_stretch = 1;
    run(5 * FRAME, 0);
    check_val("p2_pulses", 32'(pulses), 1);
    check_val("p2_unlock", 32'(saw_unlock), 1);
    check_val("p2_relock", 32'(locked_o), 1);

    // missing hsync pulse
    start_phase();
    arm_drop = 1;
    run(5 * FRAME, 0);
    check_val("p3_pulses", 32'(pulses), 1);
    check_val("p3_unlock", 32'(saw_unlock), 1);
    check_val("p3_relock", 32'(locked_o), 1);

    // vsync delayed by one line for one frame
    start_phase();
    arm_vdelay = 1;
    run(7 * FRAME, 0);
    check_val("p4_err_seen", 32'(pulses > 0), 1);
    check_val("p4_unlock", 32'(saw_unlock), 1);
    check_val("p4_relock", 32'(locked_o), 1);

    // reacquire on a 1-in-4 strobe, then on a random strobe
    step(1'b1, 1'b1);
    start_phase();
    chk_gen = 1;
    run(4 * 5 * FRAME, 1);
    check_val("p5_lock", 32'(locked_o), 1);
    check_val("p5_pulses", 32'(pulses), 0);
    run(2 * 5 * FRAME, 2);
    chk_gen = 0;
    check_val("p5r_lock", 32'(locked_o), 1);
    check_val("p5r_pulses", 32'(pulses), 0);

    // reset mid-frame while locked
    run(150, 0);
    step(1'b1, 1'b1);
    check_val("p6_h", 32'(hcount_o), 0);
    check_val("p6_v", 32'(vcount_o), 0);
    check_val("p6_lock", 32'(locked_o), 0);
    run(5 * FRAME, 0);
    check_val("p6_relock", 32'(locked_o), 1);

    // random fault campaign
    for (int k = 0; k < 6; k++) begin
      case ($urandom_range(0, 4))
        1: arm_stretch = 1;
        2: arm_drop = 1;
        3: arm_vdelay = 1;
        4: begin
          glitch_h = $urandom_range(0, HT - 1);
          arm_glitch = 1;
        end
        default: ;
      endcase
      run(7 * FRAME, 0);
      check_val("rnd_relock", 32'(locked_o), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
